linked_list_fifo_mq: RTL and testbench

- Multi-queue FIFO: FIFOS logical queues share one DEPTH-entry data RAM through linked lists and a common free list.
- Successor to the single-port-pair linked-list FIFO; adds ready/valid handshakes, a valid-tagged registered read, a per-queue empty vector and sticky error flags.
- Free list and queue pointers are rebuilt by a synchronous-reset init sequencer; there is no reliance on power-up initial values.
- Used as the shared packet/descriptor buffer in front of multi-channel arbiters.

---
 rtl/llf_pkg.sv | 29 ++
 rtl/llf_ram.sv | 34 +++
 rtl/linked_list_fifo_mq.sv | 199 +++++++++++++++++++
 tb/tb_linked_list_fifo_mq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/llf_pkg.sv
// Shared definitions for the multi-queue linked-list FIFO: width helper,
// sequencer state encoding and the null-pointer value of the free list.
package llf_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } llf_state_t;

    // Number of bits needed to represent v (at least 1).
    function automatic int log2(input int v);
        int n;
        int x;
        n = 0;
        x = v;
        while (x > 0) begin
            n = n + 1;
            x = x >> 1;
        end
        if (n == 0) n = 1;
        return n;
    endfunction

    // Free-list terminator: one past the last node, so only its top bit is set.
    function automatic int null_ptr(input int depth);
        return depth;
    endfunction

endpackage

// File: rtl/llf_ram.sv
// Node storage: data array with registered read, link array with
// combinational read. One write address and one read address are shared
// by both arrays.
module llf_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int PW    = 7
) (
    input  logic             clk,
    input  logic [AW-1:0]    wr_addr,
    input  logic             data_we,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             link_we,
    input  logic [PW-1:0]    link_wr_data,
    input  logic [AW-1:0]    rd_addr,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [PW-1:0]    link_rd_data
);

    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [PW-1:0]    link_mem [DEPTH];

    // Writes to both arrays and the registered data read.
    always_ff @(posedge clk) begin
        if (data_we) data_mem[wr_addr] <= wr_data;
        if (link_we) link_mem[wr_addr] <= link_wr_data;
        if (rd_en)   rd_data <= data_mem[rd_addr];
    end

    assign link_rd_data = link_mem[rd_addr];

endmodule

// File: rtl/linked_list_fifo_mq.sv
// Multi-queue FIFO: FIFOS logical queues share one DEPTH-entry RAM through
// per-queue linked lists and a common free list. Each queue owns a sentinel
// node, so a queue is empty when its begin and end pointers match.
// Optional feature macro: LLF_COUNTERS_EN adds per-queue occupancy counts.
module linked_list_fifo_mq
    import llf_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 64,
    parameter int FIFOS      = 8,
    parameter int LOG2_DEPTH = log2(DEPTH - 1),
    parameter int LOG2_FIFOS = log2(FIFOS - 1),
    parameter int AF_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [LOG2_FIFOS-1:0] push_fifo,
    input  logic [WIDTH-1:0]      d,
    output logic                  push_ready,
    input  logic                  pop,
    input  logic [LOG2_FIFOS-1:0] pop_fifo,
    output logic                  pop_ready,
    output logic [WIDTH-1:0]      q,
    output logic                  q_valid,
    output logic [FIFOS-1:0]      empty_vec,
    output logic                  full,
    output logic                  almost_full,
    output logic [LOG2_DEPTH:0]   free_count,
    output logic                  init_busy,
    output logic                  overflow,
    output logic                  underflow
`ifdef LLF_COUNTERS_EN
    ,
    output logic [FIFOS*(LOG2_DEPTH+1)-1:0] count
`endif
);

    localparam int AW = LOG2_DEPTH;
    localparam int PW = LOG2_DEPTH + 1;
    localparam logic [PW-1:0] NULL_PTR       = PW'(null_ptr(DEPTH));
    localparam logic [AW-1:0] LAST_IDX       = AW'(DEPTH - 1);
    localparam logic [PW-1:0] FREE_HEAD_INIT = PW'(FIFOS);
    localparam logic [PW-1:0] FREE_CNT_INIT  = PW'(DEPTH - FIFOS);

    // Handshake contract: a request is taken on a rising clk edge when both
    // its request and ready are high; ready never depends on the same port's
    // request, and push_ready depends on pop only to allow push-while-full.

    llf_state_t    state_q, state_d;
    logic [AW-1:0] init_idx_q, init_idx_d;
    logic [AW-1:0] beg_q [FIFOS];
    logic [AW-1:0] end_q [FIFOS];
    logic [PW-1:0] free_head_q;
    logic [PW-1:0] free_count_q;

    logic          run, init_last, push_acc, pop_acc;
    logic [AW-1:0] pop_node, push_tail;
    logic [AW-1:0] wr_addr, rd_addr;
    logic          data_we, link_we;
    logic [PW-1:0] link_wr_data, link_rd_data;

    assign run       = (state_q == ST_RUN);
    assign init_last = (state_q == ST_INIT) && (init_idx_q == LAST_IDX);
    assign pop_node  = beg_q[pop_fifo];
    assign push_tail = end_q[push_fifo];

    for (genvar f = 0; f < FIFOS; f++) begin : g_empty
        assign empty_vec[f] = (beg_q[f] == end_q[f]);
    end

    assign init_busy   = !run;
    assign full        = free_head_q[AW];
    assign almost_full = free_count_q < PW'(AF_THRESH);
    assign free_count  = free_count_q;
    assign pop_ready   = run & !empty_vec[pop_fifo];
    assign pop_acc     = pop & pop_ready;
    assign push_ready  = run & (!full | pop_acc);
    assign push_acc    = push & push_ready;

    // A pop reads its head node; a lone push reads the free-list successor.
    assign rd_addr = pop_acc ? pop_node : free_head_q[AW-1:0];

    // Sequencer state register; reset restarts the link rebuild.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    // Sequencer next state: walk every node once, then run.
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        if (state_q == ST_INIT) begin
            init_idx_d = init_idx_q + AW'(1);
            if (init_idx_q == LAST_IDX) state_d = ST_RUN;
        end
    end

    // RAM write steering: init chain, push append, or freed-node return.
    always_comb begin
        wr_addr      = '0;
        data_we      = 1'b0;
        link_we      = 1'b0;
        link_wr_data = '0;
        if (state_q == ST_INIT) begin
            wr_addr      = init_idx_q;
            link_we      = 1'b1;
            link_wr_data = init_last ? NULL_PTR : ({1'b0, init_idx_q} + PW'(1));
        end else if (push_acc) begin
            // With a simultaneous pop the popped node becomes the new sentinel.
            wr_addr      = push_tail;
            data_we      = 1'b1;
            link_we      = 1'b1;
            link_wr_data = pop_acc ? {1'b0, pop_node} : free_head_q;
        end else if (pop_acc) begin
            wr_addr      = pop_node;
            link_we      = 1'b1;
            link_wr_data = free_head_q;
        end
    end

    // Queue pointers and free list.
    always_ff @(posedge clk) begin
        if (init_last) begin
            for (int f = 0; f < FIFOS; f++) begin
                beg_q[f] <= AW'(f);
                end_q[f] <= AW'(f);
            end
            free_head_q  <= FREE_HEAD_INIT;
            free_count_q <= FREE_CNT_INIT;
        end else begin
            if (push_acc) end_q[push_fifo] <= pop_acc ? pop_node : free_head_q[AW-1:0];
            if (pop_acc)  beg_q[pop_fifo]  <= link_rd_data[AW-1:0];
            if (push_acc && !pop_acc) begin
                free_head_q  <= link_rd_data;
                free_count_q <= free_count_q - PW'(1);
            end else if (pop_acc && !push_acc) begin
                free_head_q  <= {1'b0, pop_node};
                free_count_q <= free_count_q + PW'(1);
            end
        end
    end

    // Read-valid tag and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            q_valid <= pop_acc;
            if (push && !push_ready && !init_busy) overflow  <= 1'b1;
            if (pop  && !pop_ready  && !init_busy) underflow <= 1'b1;
        end
    end

    llf_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW),
        .PW    (PW)
    ) u_ram (
        .clk          (clk),
        .wr_addr      (wr_addr),
        .data_we      (data_we),
        .wr_data      (d),
        .link_we      (link_we),
        .link_wr_data (link_wr_data),
        .rd_addr      (rd_addr),
        .rd_en        (pop_acc),
        .rd_data      (q),
        .link_rd_data (link_rd_data)
    );

`ifdef LLF_COUNTERS_EN
    logic [PW-1:0] cnt_q [FIFOS];

    // Per-queue occupancy; a same-queue push+pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (init_last) begin
            for (int f = 0; f < FIFOS; f++) cnt_q[f] <= '0;
        end else if (!(push_acc && pop_acc && (push_fifo == pop_fifo))) begin
            if (push_acc) cnt_q[push_fifo] <= cnt_q[push_fifo] + PW'(1);
            if (pop_acc)  cnt_q[pop_fifo]  <= cnt_q[pop_fifo] - PW'(1);
        end
    end

    for (genvar f = 0; f < FIFOS; f++) begin : g_count
        assign count[f*PW +: PW] = cnt_q[f];
    end
`endif

endmodule

// File: tb/tb_linked_list_fifo_mq.sv
// Bench for linked_list_fifo_mq at DEPTH=16, FIFOS=4, WIDTH=8: reset/init
// timing, a table of directed vectors, full/overflow/underflow corners,
// same-queue push+pop, randomized traffic and mid-stream reset, all checked
// against per-queue reference queues.
module tb_linked_list_fifo_mq;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int F  = 4;
    localparam int PW = 5;
    localparam int CAP = D - F;

    logic         clk = 1'b0;
    logic         rst;
    logic         push, pop;
    logic [1:0]   push_fifo, pop_fifo;
    logic [W-1:0] d;
    logic         push_ready, pop_ready;
    logic [W-1:0] q;
    logic         q_valid;
    logic [F-1:0] empty_vec;
    logic         full, almost_full;
    logic [PW-1:0] free_count;
    logic         init_busy, overflow, underflow;
`ifdef LLF_COUNTERS_EN
    logic [F*PW-1:0] count;
`endif

    linked_list_fifo_mq #(
        .WIDTH (W),
        .DEPTH (D),
        .FIFOS (F)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_fifo   (push_fifo),
        .d           (d),
        .push_ready  (push_ready),
        .pop         (pop),
        .pop_fifo    (pop_fifo),
        .pop_ready   (pop_ready),
        .q           (q),
        .q_valid     (q_valid),
        .empty_vec   (empty_vec),
        .full        (full),
        .almost_full (almost_full),
        .free_count  (free_count),
        .init_busy   (init_busy),
        .overflow    (overflow),
        .underflow   (underflow)
`ifdef LLF_COUNTERS_EN
        ,
        .count       (count)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // ---------------- reference model / scoreboard ----------------
    logic [W-1:0] mq [F][$];
    logic [W-1:0] exp_q [$];
    logic         m_ovf, m_udf;
    int           n_checks = 0;
    int           n_fail   = 0;

    function automatic int m_free();
        int used;
        used = 0;
        for (int f = 0; f < F; f++) used += mq[f].size();
        return CAP - used;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        logic [F-1:0] ev;
        for (int f = 0; f < F; f++) ev[f] = (mq[f].size() == 0);
        check("empty_vec", 32'(empty_vec), 32'(ev));
        check("free_count", 32'(free_count), 32'(m_free()));
        check("full", 32'(full), 32'(m_free() == 0));
        check("almost_full", 32'(almost_full), 32'(m_free() < 2));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_udf));
        check("init_busy", 32'(init_busy), 32'(0));
`ifdef LLF_COUNTERS_EN
        for (int f = 0; f < F; f++)
            check("count", 32'(count[f*PW +: PW]), 32'(mq[f].size()));
`endif
    endtask

    // ---------------- driver ----------------
    // Called at a negedge; applies one cycle of requests and checks results.
    task automatic step(input logic p, input logic [1:0] pf, input logic [W-1:0] dv,
                        input logic po, input logic [1:0] qf);
        logic pop_ok, push_ok;
        push = p; push_fifo = pf; d = dv; pop = po; pop_fifo = qf;
        #1;
        pop_ok  = (mq[qf].size() > 0);
        push_ok = (m_free() > 0) || (po && pop_ok);
        check("pop_ready", 32'(pop_ready), 32'(pop_ok));
        check("push_ready", 32'(push_ready), 32'(push_ok));
        if (po && pop_ok) exp_q.push_back(mq[qf].pop_front());
        if (p && push_ok) mq[pf].push_back(dv);
        if (p && !push_ok) m_ovf = 1'b1;
        if (po && !pop_ok) m_udf = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("q_valid", 32'(q_valid), 32'(po && pop_ok));
        if (po && pop_ok) check("q", 32'(q), 32'(exp_q.pop_front()));
        check_state();
    endtask

    task automatic idle();
        push = 1'b0; pop = 1'b0; push_fifo = '0; pop_fifo = '0; d = '0;
    endtask

    task automatic do_reset();
        int n;
        idle();
        rst = 1'b1;
        for (int f = 0; f < F; f++) mq[f].delete();
        exp_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_init_busy", 32'(init_busy), 32'(1));
        check("rst_push_ready", 32'(push_ready), 32'(0));
        check("rst_pop_ready", 32'(pop_ready), 32'(0));
        check("rst_q_valid", 32'(q_valid), 32'(0));
        check("rst_overflow", 32'(overflow), 32'(0));
        check("rst_underflow", 32'(underflow), 32'(0));
        rst = 1'b0;
        n = 0;
        while (init_busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("init_cycles", 32'(n), 32'(D));
        check_state();
        check("post_init_push_ready", 32'(push_ready), 32'(1));
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       push;
        logic [1:0] pf;
        logic [7:0] d;
        logic       pop;
        logic [1:0] qf;
        logic       exp_qv;
        logic [7:0] exp_q;
        int         exp_free;
    } vec_t;

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{1'b1, 2'd2, 8'h11, 1'b0, 2'd0, 1'b0, 8'h00, 11};
        vecs[1]  = '{1'b1, 2'd2, 8'h22, 1'b0, 2'd0, 1'b0, 8'h00, 10};
        vecs[2]  = '{1'b1, 2'd2, 8'h33, 1'b0, 2'd0, 1'b0, 8'h00, 9};
        vecs[3]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b1, 8'h11, 10};
        vecs[4]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b1, 8'h22, 11};
        vecs[5]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b1, 8'h33, 12};
        vecs[6]  = '{1'b1, 2'd0, 8'hA0, 1'b0, 2'd0, 1'b0, 8'h00, 11};
        vecs[7]  = '{1'b1, 2'd3, 8'hB0, 1'b0, 2'd0, 1'b0, 8'h00, 10};
        vecs[8]  = '{1'b1, 2'd0, 8'hA1, 1'b0, 2'd0, 1'b0, 8'h00, 9};
        vecs[9]  = '{1'b1, 2'd3, 8'hB1, 1'b0, 2'd0, 1'b0, 8'h00, 8};
        vecs[10] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b1, 8'hB0, 9};
        vecs[11] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b1, 8'hA0, 10};
        vecs[12] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b1, 8'hA1, 11};
        vecs[13] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b1, 8'hB1, 12};

        do_reset();

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].push, vecs[i].pf, vecs[i].d, vecs[i].pop, vecs[i].qf);
            check("tbl_q_valid", 32'(q_valid), 32'(vecs[i].exp_qv));
            if (vecs[i].exp_qv) check("tbl_q", 32'(q), 32'(vecs[i].exp_q));
            check("tbl_free", 32'(free_count), 32'(vecs[i].exp_free));
        end

        // Fill all usable entries, then overflow and push+pop while full.
        for (int i = 0; i < CAP; i++) begin
            step(1'b1, 2'(i % F), 8'($urandom_range(0, 255)), 1'b0, 2'd0);
            if (i == CAP - 2) check("af_at_one", 32'(almost_full), 32'(1));
        end
        check("full_set", 32'(full), 32'(1));
        step(1'b1, 2'd0, 8'hEE, 1'b0, 2'd0);
        check("overflow_set", 32'(overflow), 32'(1));
        check("overflow_free", 32'(free_count), 32'(0));
        step(1'b1, 2'd1, 8'h77, 1'b1, 2'd2);
        check("full_pushpop_q_valid", 32'(q_valid), 32'(1));
        check("full_pushpop_free", 32'(free_count), 32'(0));

        // Drain every queue.
        for (int f = 0; f < F; f++)
            for (int k = 0; k < 16; k++)
                if (mq[f].size() > 0) step(1'b0, 2'd0, 8'h00, 1'b1, 2'(f));

        // Pop of an empty queue.
        step(1'b0, 2'd0, 8'h00, 1'b1, 2'd1);
        check("underflow_set", 32'(underflow), 32'(1));
        check("underflow_q_valid", 32'(q_valid), 32'(0));

        // Same queue, one element, push+pop together.
        step(1'b1, 2'd1, 8'h5A, 1'b0, 2'd0);
        step(1'b1, 2'd1, 8'hA5, 1'b1, 2'd1);
        check("sameq_old", 32'(q), 32'(8'h5A));
        check("sameq_not_empty", 32'(empty_vec[1]), 32'(0));
        step(1'b0, 2'd0, 8'h00, 1'b1, 2'd1);
        check("sameq_new", 32'(q), 32'(8'hA5));
        check("sameq_empty", 32'(empty_vec[1]), 32'(1));

        // Randomized traffic, push-heavy then pop-heavy.
        for (int i = 0; i < 400; i++) begin
            int bias;
            bias = (i < 200) ? 70 : 35;
            step($urandom_range(0, 99) < bias, 2'($urandom_range(0, 3)),
                 8'($urandom_range(0, 255)),
                 $urandom_range(0, 99) < (100 - bias), 2'($urandom_range(0, 3)));
        end

        // Mid-stream reset with five stored entries.
        do_reset();
        for (int i = 0; i < 5; i++)
            step(1'b1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1'b0, 2'd0);
        check("pre_reset_free", 32'(free_count), 32'(CAP - 5));
        do_reset();
        check("reset_all_empty", 32'(empty_vec), 32'(4'b1111));
        check("reset_free", 32'(free_count), 32'(CAP));
`ifdef LLF_COUNTERS_EN
        check("reset_counts", 32'(count), 32'(0));
`endif

        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
